// File: rtl/mem_txn_sequencer.sv
// RAM transaction sequencer: runs MAR-load / RAM-enable / MFC handshakes for single and
// double-word SPARC loads and stores, with alignment checking, MFC timeout and trap reporting.
module mem_txn_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                Clk,
    input  logic                RESET,
    input  logic                req,
    input  logic [5:0]          op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] rdata,
    output logic                trap,
    output logic [2:0]          tt,
    output logic                MAR_Enable,
    output logic                RAM_enable,
    output logic [5:0]          RAM_OpCode,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic                MFC,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int unsigned STRIDE = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] TT_ILLEGAL = 3'b010;
    localparam logic [2:0] TT_ALIGN   = 3'b011;
    localparam logic [2:0] TT_TIMEOUT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ADDR, S_ACCESS, S_XFER, S_DONE, S_TRAP
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q, addr_nx;
    logic [2*DATA_W-1:0] wdata_q, wdata_nx;
    logic                idx, idx_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx, cnt_inc;
    logic [5:0]          op_nx;
    logic [2:0]          tt_nx;
    logic [2*DATA_W-1:0] rdata_nx;
    logic [ADDR_W-1:0]   ram_addr_nx;
    logic [DATA_W-1:0]   ram_wdata_nx;
    logic                legal, aligned, dbl, is_store;

    // Op decode on the latched opcode and address
    always_comb begin
        legal   = 1'b1;
        aligned = 1'b1;
        dbl     = 1'b0;
        case (RAM_OpCode)
            6'b000001, 6'b000101, 6'b001001: aligned = 1'b1;
            6'b000010, 6'b000110, 6'b001010: aligned = ~addr_q[0];
            6'b000000, 6'b000100:            aligned = (addr_q[1:0] == 2'b00);
            6'b000011, 6'b000111: begin
                dbl     = 1'b1;
                aligned = (addr_q[2:0] == 3'b000);
            end
            default: legal = 1'b0;
        endcase
        is_store = RAM_OpCode[2];
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // Next-state and next-value logic
    always_comb begin
        state_nx     = state;
        addr_nx      = addr_q;
        wdata_nx     = wdata_q;
        idx_nx       = idx;
        cnt_nx       = cnt;
        op_nx        = RAM_OpCode;
        tt_nx        = tt;
        rdata_nx     = rdata;
        ram_addr_nx  = ram_addr;
        ram_wdata_nx = ram_wdata;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (req) begin
                    op_nx    = op;
                    addr_nx  = addr;
                    wdata_nx = wdata;
                    idx_nx   = 1'b0;
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!legal) begin
                    tt_nx    = TT_ILLEGAL;
                    state_nx = S_TRAP;
                end else if (!aligned) begin
                    tt_nx    = TT_ALIGN;
                    state_nx = S_TRAP;
                end else begin
                    ram_addr_nx  = addr_q;
                    ram_wdata_nx = wdata_q[DATA_W-1:0];
                    state_nx     = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_nx   = '0;
                state_nx = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_nx = cnt_inc;
                // MFC wins over a timeout landing on the same edge
                if (MFC) begin
                    state_nx = S_XFER;
                    if (!is_store) begin
                        if (idx) rdata_nx[2*DATA_W-1:DATA_W] = ram_rdata;
                        else     rdata_nx[DATA_W-1:0]        = ram_rdata;
                    end
                end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
                    tt_nx    = TT_TIMEOUT;
                    state_nx = S_TRAP;
                end
            end
            S_XFER: begin
                cnt_nx = '0;
                if (dbl && !idx) begin
                    idx_nx       = 1'b1;
                    ram_addr_nx  = ram_addr + ADDR_W'(STRIDE);
                    ram_wdata_nx = wdata_q[2*DATA_W-1:DATA_W];
                    state_nx     = S_ADDR;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_TRAP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            idx        <= 1'b0;
            cnt        <= '0;
            RAM_OpCode <= '0;
            tt         <= '0;
            rdata      <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trap       <= 1'b0;
            MAR_Enable <= 1'b0;
            RAM_enable <= 1'b0;
        end else begin
            state      <= state_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            RAM_OpCode <= op_nx;
            tt         <= tt_nx;
            rdata      <= rdata_nx;
            ram_addr   <= ram_addr_nx;
            ram_wdata  <= ram_wdata_nx;
            busy       <= (state_nx != S_IDLE);
            done       <= (state_nx == S_DONE);
            trap       <= (state_nx == S_TRAP);
            MAR_Enable <= (state_nx == S_ADDR);
            RAM_enable <= (state_nx == S_ACCESS);
        end
    end

endmodule

// File: tb/tb_mem_txn_sequencer.sv
// Directed bench for mem_txn_sequencer: RAM responder in the sampling loop, hand-computed
// cycle numbers and data for loads, stores, traps, timeouts and asynchronous reset.
module tb_mem_txn_sequencer;

    logic        Clk = 1'b0;
    logic        RESET;
    logic        req;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        busy, done, trap;
    logic [63:0] rdata;
    logic [2:0]  tt;
    logic        MAR_Enable, RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        MFC;
    logic [31:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    int done_cyc, trap_cyc, done_n, trap_n, mar_n, en_n, trap_en;
    logic [31:0] addr_log[$];
    logic [31:0] wd_log[$];

    mem_txn_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .Clk(Clk), .RESET(RESET), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .trap(trap), .tt(tt),
        .MAR_Enable(MAR_Enable), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .MFC(MFC), .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h20:  return 32'h11111111;
            32'h24:  return 32'h22222222;
            default: return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    // Issue one request and follow it to IDLE. The RAM answers the first `answer` accesses
    // after `wait_n` wait cycles; mfc_always drives MFC=1 in every cycle instead.
    task automatic run_txn(input logic [5:0] o, input logic [31:0] a, input logic [63:0] wd,
                           input int wait_n, input int answer, input bit mfc_always,
                           input bit req_again);
        int acc;
        int answered;
        acc = 0;
        answered = 0;
        done_cyc = -1; trap_cyc = -1; done_n = 0; trap_n = 0;
        mar_n = 0; en_n = 0; trap_en = 0;
        addr_log.delete();
        wd_log.delete();
        @(negedge Clk);
        req = 1'b1; op = o; addr = a; wdata = wd;
        @(posedge Clk);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge Clk);
            if (!(req_again && cyc == 1)) req = 1'b0;
            if (MAR_Enable) begin
                mar_n++;
                addr_log.push_back(ram_addr);
                wd_log.push_back(ram_wdata);
            end
            if (RAM_enable) en_n++;
            if (done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
            if (trap) begin
                trap_n++;
                if (trap_cyc < 0) trap_cyc = cyc;
                if (RAM_enable) trap_en++;
            end
            if (mfc_always) begin
                MFC = 1'b1;
                ram_rdata = mem_word(ram_addr);
            end else if (RAM_enable) begin
                if (answered < answer && acc >= wait_n) begin
                    MFC = 1'b1;
                    ram_rdata = mem_word(ram_addr);
                    answered++;
                end else begin
                    MFC = 1'b0;
                    acc++;
                end
            end else begin
                MFC = 1'b0;
                acc = 0;
            end
            if (!busy) break;
        end
        MFC = 1'b0;
        check("txn_ends_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        RESET = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
        MFC = 1'b0; ram_rdata = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_pulses", {60'd0, done, trap, MAR_Enable, RAM_enable}, 64'd0);
        check("rst_tt_op", {55'd0, tt, RAM_OpCode}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_ram",   {ram_addr, ram_wdata}, 64'd0);
        RESET = 1'b1;

        // single LD, MFC on first ACCESS cycle
        run_txn(6'b000000, 32'h10, 64'd0, 0, 99, 1'b0, 1'b0);
        check("ld_done_cyc", 64'(done_cyc), 64'd5);
        check("ld_pulses", {32'(done_n), 32'(trap_n)}, {32'd1, 32'd0});
        check("ld_mar_en", {32'(mar_n), 32'(en_n)}, {32'd1, 32'd1});
        check("ld_addr", 64'(addr_log[0]), 64'h10);
        check("ld_rdata", rdata, 64'h00000000_DEADBEEF);

        // LD with two MFC wait cycles
        run_txn(6'b000000, 32'h44, 64'd0, 2, 99, 1'b0, 1'b0);
        check("ldw_done_cyc", 64'(done_cyc), 64'd7);
        check("ldw_en", 64'(en_n), 64'd3);
        check("ldw_rdata", rdata, 64'h00000000_0044C0DE);

        // LDD, second word at +4
        run_txn(6'b000011, 32'h20, 64'd0, 0, 99, 1'b0, 1'b0);
        check("ldd_done_cyc", 64'(done_cyc), 64'd8);
        check("ldd_mar_en", {32'(mar_n), 32'(en_n)}, {32'd2, 32'd2});
        check("ldd_addrs", {addr_log[0], addr_log[1]}, {32'h20, 32'h24});
        check("ldd_rdata", rdata, 64'h22222222_11111111);
        check("ldd_opcode", 64'(RAM_OpCode), 64'h03);

        // LDD with MFC high in every cycle: only ACCESS cycles take it
        run_txn(6'b000011, 32'hFFFFFFF8, 64'd0, 0, 99, 1'b1, 1'b0);
        check("lddm_done_cyc", 64'(done_cyc), 64'd8);
        check("lddm_addrs", {addr_log[0], addr_log[1]}, {32'hFFFFFFF8, 32'hFFFFFFFC});
        check("lddm_rdata", rdata, 64'hFFFCC0DE_FFF8C0DE);

        // STD: store words in order, rdata untouched
        run_txn(6'b000111, 32'h38, 64'hAAAA5555_12345678, 0, 99, 1'b0, 1'b0);
        check("std_done_cyc", 64'(done_cyc), 64'd8);
        check("std_addrs", {addr_log[0], addr_log[1]}, {32'h38, 32'h3C});
        check("std_wdata", {wd_log[0], wd_log[1]}, 64'h12345678_AAAA5555);
        check("std_rdata", rdata, 64'hFFFCC0DE_FFF8C0DE);

        // STB at odd address is legal
        run_txn(6'b000101, 32'h41, 64'h55, 0, 99, 1'b0, 1'b0);
        check("stb_done_cyc", 64'(done_cyc), 64'd5);

        // ST misaligned
        run_txn(6'b000100, 32'h22, 64'd0, 0, 99, 1'b0, 1'b0);
        check("st_mis_trap", {32'(trap_cyc), 32'(tt)}, {32'd2, 32'd3});
        check("st_mis_ram", {32'(mar_n), 32'(en_n)}, 64'd0);
        check("st_mis_done", 64'(done_n), 64'd0);

        // LDSH misaligned halfword
        run_txn(6'b001010, 32'h51, 64'd0, 0, 99, 1'b0, 1'b0);
        check("ldsh_mis_trap", {32'(trap_cyc), 32'(tt)}, {32'd2, 32'd3});

        // LD with MFC never arriving: 15 ACCESS cycles then timeout trap
        run_txn(6'b000000, 32'h60, 64'd0, 0, 0, 1'b0, 1'b0);
        check("to_en", 64'(en_n), 64'd15);
        check("to_trap", {32'(trap_cyc), 32'(tt)}, {32'd18, 32'd4});
        check("to_trap_en", {32'(trap_en), 32'(done_n)}, 64'd0);
        check("to_rdata", rdata, 64'hFFFCC0DE_FFF8C0DE);

        // MFC on the same edge the counter reaches TIMEOUT
        run_txn(6'b000000, 32'h60, 64'd0, 14, 99, 1'b0, 1'b0);
        check("edge_done", {32'(done_cyc), 32'(trap_n)}, {32'd19, 32'd0});
        check("edge_rdata", rdata, 64'hFFFCC0DE_0060C0DE);

        // LDD second word times out: first half already updated
        run_txn(6'b000011, 32'h50, 64'd0, 0, 1, 1'b0, 1'b0);
        check("ldd_to_trap", {32'(trap_cyc), 32'(tt)}, {32'd21, 32'd4});
        check("ldd_to_en", 64'(en_n), 64'd16);
        check("ldd_to_rdata", rdata, 64'hFFFCC0DE_0050C0DE);

        // Illegal op with a second req while busy
        run_txn(6'b111111, 32'h0, 64'd0, 0, 99, 1'b0, 1'b1);
        check("ill_trap", {32'(trap_cyc), 32'(tt)}, {32'd2, 32'd2});
        check("ill_count", {32'(trap_n), 32'(done_n)}, {32'd1, 32'd0});
        repeat (3) begin
            @(negedge Clk);
            check("ill_stay_idle", {62'd0, busy, trap}, 64'd0);
        end

        // STD aborted by asynchronous reset during the first ACCESS
        @(negedge Clk);
        req = 1'b1; op = 6'b000111; addr = 32'h30; wdata = 64'h1;
        @(posedge Clk);
        repeat (3) @(negedge Clk);
        req = 1'b0;
        check("rs_access", {62'd0, RAM_enable, busy}, 64'd3);
        #2 RESET = 1'b0;
        #1;
        check("rs_async_drop", {61'd0, RAM_enable, busy, MAR_Enable}, 64'd0);
        check("rs_rdata_clr", rdata, 64'd0);
        @(negedge Clk);
        #2 RESET = 1'b1;
        done_n = 0; trap_n = 0;
        repeat (5) begin
            @(negedge Clk);
            if (done) done_n++;
            if (trap) trap_n++;
        end
        check("rs_no_pulse", {32'(done_n), 32'(trap_n)}, 64'd0);
        run_txn(6'b000000, 32'h10, 64'd0, 0, 99, 1'b0, 1'b0);
        check("rs_after_done", 64'(done_cyc), 64'd5);
        check("rs_after_rdata", rdata, 64'h00000000_DEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
